pixel_writer: RTL
=================

Name: pixel_writer

Overview:
- Downstream consumer of the rasterizer's serial pixel outputs.
- Deserializes the three 16-bit serial lanes: PX and PY (Q10.6 coordinates) and C (RGB555+A1 colour).
- Converts each pixel to a linear 320x240 framebuffer address, bounds-checks it and buffers it in a small FIFO.
- Drains the FIFO through a ready/valid framebuffer write port, and reports triangle completion once all pixels of the triangle have been written.

Parameters:
FRAC, 6, fractional bits of incoming coordinates
SCR_W, 320, screen width in pixels
SCR_H, 240, screen height in pixels
FIFO_DEPTH, 4, pixel FIFO entries (power of 2)
ADDR_W, 17, framebuffer address width (ceil log2 of SCR_W*SCR_H)

Ports:
CLK  in  1  clock
RST  in  1  reset; synchronous, active-high
VALID  in  1  one-cycle pulse marking the start of a pixel word on PX/PY/C
PX  in  1  serial x coordinate, Q10.6, MSB first
PY  in  1  serial y coordinate, Q10.6, MSB first
C  in  1  serial colour, MSB first
DONE  in  1  one-cycle pulse: rasterizer finished the triangle
FB_ADDR  out  ADDR_W  framebuffer write address
FB_DATA  out  16  framebuffer write data (colour)
FB_WE  out  1  write request; held until accepted
FB_READY  in  1  framebuffer accepts the write when FB_WE && FB_READY
TRI_DONE  out  1  one-cycle pulse: triangle fully written
BUSY  out  1  capture in progress, FIFO non-empty, or DONE pending
DROP_CNT  out  16  count of pixels discarded (out of bounds or FIFO full)
PROTO_ERR  out  1  sticky: VALID seen mid-word; cleared only by RST

Behaviour:
- Reset:
  - All outputs 0.
  - FIFO empty; capture FSM in IDLE; done_pending cleared.
- Serial framing:
  - Bit 15 of each lane is present on the cycle after VALID is high.
  - Bits 14..0 follow on the next 15 consecutive cycles, MSB first, with all three lanes aligned.
- Capture FSM, states IDLE and SHIFT:
  - IDLE -> SHIFT on VALID; the bit counter is loaded with 15.
  - SHIFT: each cycle, shift PX, PY and C into their 16-bit registers and decrement the counter.
  - When the counter reaches 0 with the 16th bit shifted in, the word is complete; return to IDLE.
- Word-complete pipeline:
  - The cycle after word-complete, run the convert stage as a single registered stage: xi = X[15:FRAC], yi = Y[15:FRAC].
  - A coordinate whose sign bit is set is out of bounds.
  - In bounds requires xi < SCR_W and yi < SCR_H.
  - addr = yi*SCR_W + xi, implemented as (yi<<8)+(yi<<6)+xi at the default SCR_W, truncated to ADDR_W.
- FIFO push:
  - An in-bounds pixel is pushed {addr, colour} on the convert cycle.
  - If the pixel is out of bounds, or the FIFO is full on that cycle, it is not pushed and DROP_CNT increments.
  - DROP_CNT saturates at 0xFFFF.
- VALID during SHIFT:
  - PROTO_ERR is set and the partial word is discarded without counting as a drop.
  - The counter reloads to 15 and capture restarts.
- VALID on the same cycle as word-complete:
  - This is legal back-to-back framing.
  - The word completes normally and a new SHIFT begins.
- FIFO:
  - Push and pop may occur in the same cycle; occupancy is unchanged.
  - Push when full is a drop.
  - Pop when empty never occurs.
- Write port:
  - FB_WE = FIFO non-empty; FB_ADDR and FB_DATA present the FIFO head.
  - Pop on FB_WE && FB_READY.
  - Address and data are stable while FB_WE is high and FB_READY is low.
- Latency: first FB_WE rises 2 cycles after the 16th bit, i.e. 18 cycles after VALID, with the FIFO empty.
- DONE handling:
  - DONE sets done_pending, even if it coincides with a word in flight.
  - TRI_DONE pulses one cycle when all of the following hold: done_pending, capture IDLE, no convert in progress, and FIFO empty.
  - The pulse clears done_pending.
  - A DONE arriving while done_pending is already set is absorbed, giving one TRI_DONE.
- BUSY = (state != IDLE) | convert_valid | FIFO non-empty | done_pending.
- RST asserted mid-word or mid-drain:
  - Aborts everything next edge; the FIFO is flushed and no TRI_DONE is issued.
  - DROP_CNT and PROTO_ERR are cleared.

Decomposition:
- Shared package (raster_pkg): FRAC, SCR_W, SCR_H, ADDR_W, and the colour field positions (R[15:11], G[10:6], B[5:1], A[0]).
- Sub-module pixel_fifo: synchronous FIFO, parameterised width/depth, with full/empty flags and same-cycle push/pop.
- The top module holds the capture FSM, convert stage, counters and done logic.

Test Plan:
- Single pixel:
  - Stimulus: VALID, then X=0x0A00 (40.0), Y=0x0140 (5.0), C=0xF801; FB_READY=1.
  - Response: FB_WE for one cycle 18 cycles after VALID with FB_ADDR=1640, FB_DATA=0xF801.
  - DONE afterwards -> TRI_DONE pulse once, BUSY falls.
- Bounds:
  - X=0x5000 (320.0) -> dropped, DROP_CNT=1, no FB_WE.
  - X=0xFFC0 (-1.0) -> dropped, DROP_CNT=2.
  - X=0x4FC0 (319), Y=0x3BC0 (239) -> FB_ADDR=76799.
- Backpressure:
  - Stimulus: FB_READY=0; send 6 back-to-back pixels with VALID every 16 cycles.
  - Response: 4 buffered, DROP_CNT=2, FB_ADDR/FB_DATA stable.
  - Release FB_READY -> 4 writes in order of arrival.
- DONE mid-traffic:
  - Stimulus: DONE asserted during the 10th bit of the last word, FB_READY toggling 1/0.
  - Response: TRI_DONE only after the final write is accepted, exactly one pulse.
- Protocol error:
  - Stimulus: VALID at bit 8 of a word.
  - Response: PROTO_ERR=1, the first word is discarded, the second word is written correctly, DROP_CNT unchanged.
- Reset mid-drain:
  - Stimulus: 3 pixels queued with FB_READY=0, then RST for 1 cycle.
  - Response: FB_WE=0, BUSY=0, DROP_CNT=0, and no TRI_DONE even if DONE was pending.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared raster constants, framebuffer pixel record and address helper.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package raster_pkg;

    localparam int FRAC   = 6;
    localparam int SCR_W  = 320;
    localparam int SCR_H  = 240;
    localparam int ADDR_W = 17;
    localparam int IW     = 16 - FRAC;

    typedef struct packed {
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
        logic       a;
    } colour_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        colour_t           colour;
    } pix_t;

    // y*320 + x as two shifts and an add; only valid while SCR_W is 320.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [IW-1:0] xi,
                                                   input logic [IW-1:0] yi);
        logic [ADDR_W-1:0] y;
        y = ADDR_W'(yi);
        return (y << 8) + (y << 6) + ADDR_W'(xi);
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Generic synchronous FIFO with full/empty flags and same-cycle push/pop.
// Latency: a pushed entry is visible at the head on the next cycle.
// Backpressure: caller must not push when full or pop when empty.
module pixel_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_vld) wp <= wp + (AW+1)'(1);
            if (rd_rdy) rp <= rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_vld) mem[wp[AW-1:0]] <= wr_dat;
    end

    assign rd_dat = mem[rp[AW-1:0]];
    assign empty  = (wp == rp);
    assign full   = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);

endmodule

// File: rtl/pixel_writer.sv
// Deserialises rasterizer pixel lanes, bounds-checks, buffers and writes them to the framebuffer.
// Latency: first FB_WE 18 cycles after VALID with the FIFO empty.
// Backpressure: FB_WE held until FB_READY; pixels arriving to a full FIFO are dropped and counted.
module pixel_writer
    import raster_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              VALID,
    input  logic              PX,
    input  logic              PY,
    input  logic              C,
    input  logic              DONE,
    output logic [ADDR_W-1:0] FB_ADDR,
    output logic [15:0]       FB_DATA,
    output logic              FB_WE,
    input  logic              FB_READY,
    output logic              TRI_DONE,
    output logic              BUSY,
    output logic [15:0]       DROP_CNT,
    output logic              PROTO_ERR
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]    state;
    logic [3:0]    bit_cnt;
    logic [14:0]   x_sr, y_sr, c_sr;
    logic          word_done;
    logic [IW-1:0] xi, yi;
    logic          in_bounds;
    logic          cv_vld, cv_inb;
    pix_t          cv_pix;
    logic          push_vld, pop_rdy, drop;
    logic          fifo_full, fifo_empty;
    pix_t          head;
    logic          done_pending, tri_fire;

    assign word_done = (state == ST_SHIFT) && (bit_cnt == 4'd0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            PROTO_ERR <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (VALID) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= 4'd15;
                    end
                end
                default: begin
                    // VALID on the last bit is back-to-back framing; anywhere else it aborts the word.
                    if (VALID) begin
                        bit_cnt <= 4'd15;
                        if (bit_cnt != 4'd0) PROTO_ERR <= 1'b1;
                    end else if (bit_cnt == 4'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (state == ST_SHIFT) begin
            x_sr <= {x_sr[13:0], PX};
            y_sr <= {y_sr[13:0], PY};
            c_sr <= {c_sr[13:0], C};
        end
    end

    // On word_done the full word is {sr, lane}; the lane bit is fractional, so integers come from sr.
    assign xi        = x_sr[14:FRAC-1];
    assign yi        = y_sr[14:FRAC-1];
    assign in_bounds = !x_sr[14] && !y_sr[14] && (xi < IW'(SCR_W)) && (yi < IW'(SCR_H));

    always_ff @(posedge CLK) begin
        if (RST) begin
            cv_vld <= 1'b0;
            cv_inb <= 1'b0;
            cv_pix <= '0;
        end else begin
            cv_vld        <= word_done;
            cv_inb        <= in_bounds;
            cv_pix.addr   <= pix_addr(xi, yi);
            cv_pix.colour <= {c_sr, C};
        end
    end

    assign push_vld = cv_vld && cv_inb && !fifo_full;
    assign drop     = cv_vld && !(cv_inb && !fifo_full);
    assign pop_rdy  = !fifo_empty && FB_READY;

    pixel_fifo #(
        .W     ($bits(pix_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK    (CLK),
        .RST    (RST),
        .wr_vld (push_vld),
        .wr_dat (cv_pix),
        .rd_rdy (pop_rdy),
        .rd_dat (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign FB_WE   = !fifo_empty;
    assign FB_ADDR = fifo_empty ? '0 : head.addr;
    assign FB_DATA = fifo_empty ? '0 : head.colour;

    assign tri_fire = done_pending && (state == ST_IDLE) && !cv_vld && fifo_empty;

    always_ff @(posedge CLK) begin
        if (RST) begin
            done_pending <= 1'b0;
            TRI_DONE     <= 1'b0;
            DROP_CNT     <= '0;
        end else begin
            TRI_DONE     <= tri_fire;
            done_pending <= !tri_fire && (done_pending || DONE);
            if (drop && DROP_CNT != 16'hFFFF) DROP_CNT <= DROP_CNT + 16'd1;
        end
    end

    assign BUSY = (state != ST_IDLE) || cv_vld || !fifo_empty || done_pending;

endmodule
